sha256_msg_schedule: RTL and testbench
======================================

# sha256_msg_schedule

SHA-256 message-schedule expander for the miner hash datapath. It accepts one 512-bit message block and streams the 64 schedule words W0..W63, one per accepted handshake, to the compression round engine. The round engine's final working variables feed the H0..H7 accumulator registers. The block keeps a 16-word sliding window, so no 64-word storage is required.

## Interface
- No parameters. Word width is fixed at 32 bits and the round count at 64.
- `clk`  in  1  — single clock; all state updates on the rising edge.
- `rst_n`  in  1  — asynchronous active-low reset.
- `start`  in  1  — load `block` and begin a schedule; honoured only in IDLE.
- `abort`  in  1  — synchronous abort; returns to IDLE.
- `block`  in  512  — message block, big-endian: M0 = `block[511:480]`, M15 = `block[31:0]`.
- `w_ready`  in  1  — round engine accepts the current word.
- `w_valid`  out  1  — `w_out` and `t_out` are valid.
- `w_out`  out  32  — schedule word Wt.
- `t_out`  out  6  — round index t of `w_out`.
- `busy`  out  1  — high in RUN.
- `done`  out  1  — one-cycle pulse after W63 is accepted.

## Operation
- State machine, two states:
  - **IDLE**: `w_valid` = 0, `busy` = 0.
  - **RUN**: `w_valid` = 1, `busy` = 1.
- **IDLE → RUN** on `start` = 1 with `abort` = 0:
  - window w[0..15] ← M0..M15.
  - t ← 0.
- **Window contents in RUN**: w[0..15] holds Wt..Wt+15. `w_out` = w[0], `t_out` = t.
- **Accept** = `w_valid` & `w_ready`. On accept:
  - w[i] ← w[i+1] for i = 0..14.
  - w[15] ← σ1(w[14]) + w[9] + σ0(w[1]) + w[0].
  - t ← t + 1.
- **Arithmetic**: all adds are modulo 2^32, carries discarded.
  - σ0(x) = ROTR7(x) ^ ROTR18(x) ^ SHR3(x).
  - σ1(x) = ROTR17(x) ^ ROTR19(x) ^ SHR10(x).
- **Backpressure**: while `w_ready` = 0, the window, t, `w_out` and `t_out` all hold. There is no limit on stall length.
- **Completion**: accept with t = 63 → IDLE and `done` = 1 for exactly one cycle. t does not wrap to 0 in RUN.
- **`start` in RUN**: ignored; `block` is not resampled.
- **Abort**: `abort` = 1 in any state → IDLE next cycle.
  - `done` is not pulsed.
  - The window contents become don't-care.
  - `abort` has priority over `start` and over accept.
- **Reset**: `rst_n` = 0 at any time, including mid-schedule, immediately forces:
  - IDLE, t = 0, window = 0.
  - `w_valid` = 0, `busy` = 0, `done` = 0, `w_out` = 0, `t_out` = 0.
- **Outputs in IDLE**: `w_out` and `t_out` hold their last values. Consumers must qualify them with `w_valid`.

## Timing
- All outputs are registered or decoded directly from registers; there is no combinational path from `w_ready` to any output.
- **Start latency**: `start` sampled at edge k → `w_valid` = 1, `w_out` = W0, `t_out` = 0 during cycle k+1.
- **Throughput**: one word per cycle with `w_ready` held high. With `start` at edge k, the 64 accepts occur at edges k+1..k+64.
- **Done timing**: `done` is high in cycle k+65, with `w_valid` = 0 and `busy` = 0 in the same cycle.
- **Back-to-back blocks**: `start` sampled during the `done` cycle is honoured, and W0 of the new block appears in the next cycle. A block therefore costs a minimum of 65 cycles.
- **Reset recovery**: first `start` is honoured at the first rising edge after `rst_n` deasserts.
- **Critical path**: two σ functions plus a 4-operand 32-bit add; this must close at the round engine's clock.

## Test plan
- **"abc" block, `w_ready` = 1**:
  - Stimulus: `block` = 0x61626380, 0x00000000 ×14, 0x00000018.
  - Required: W0 = 0x61626380, W15 = 0x00000018, W16 = 0x61626380, W17 = 0x000F0000, W63 = 0x12B1EDEB.
  - Required: `done` pulses at cycle k+65.
- **Random backpressure**: same block with `w_ready` randomly deasserted (up to 10-cycle stalls).
  - Required: an identical W0..W63 sequence.
  - Required: `w_out` and `t_out` are stable through every stall.
  - Required: exactly 64 accepts, then one `done` pulse.
- **Back-to-back blocks**: `start` asserted in the `done` cycle with a random second block.
  - Required: W0 of the second block at the next cycle, with no lost or duplicated words.
  - Required: both streams match a reference model.
- **`start` while busy**: assert `start` at t = 20 with a different `block`.
  - Required: the stream continues unchanged to W63.
- **Abort mid-run**: `abort` at t = 30, together with `start`.
  - Required: IDLE next cycle, `w_valid` = 0, no `done`.
  - Required: a subsequent `start` produces a correct W0..W63.
- **Async reset mid-run**: `rst_n` pulsed low between clock edges at t = 40.
  - Required: `w_valid`, `busy`, `done`, `w_out` and `t_out` all 0 immediately, with no clock edge needed.
  - Required: the next `start` after deassertion produces the correct schedule.

Source files
------------

// File: rtl/sha256_msg_schedule.sv
`default_nettype none
// ============================================================================
// Module   : sha256_msg_schedule
// Purpose  : SHA-256 message-schedule expander. It loads one 512-bit block
//            and streams W0..W63 over a valid/ready handshake. A 16-word
//            sliding window replaces the full 64-word schedule.
// Ports    : clk, rst_n          - clock, async active-low reset
//            start, abort        - begin schedule (IDLE only) / return to IDLE
//            block[511:0]        - message block, M0 = block[511:480]
//            w_ready             - round engine accepts current word
//            w_valid, w_out[31:0], t_out[5:0] - current schedule word Wt
//            busy                - schedule in progress
//            done                - one-cycle pulse after W63 is accepted
// Revision : 1.0 - initial release
// ============================================================================
module sha256_msg_schedule (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic         abort,
  input  logic [511:0] block,
  input  logic         w_ready,
  output logic         w_valid,
  output logic [31:0]  w_out,
  output logic [5:0]   t_out,
  output logic         busy,
  output logic         done
);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam logic [5:0] LAST_T = 6'd63;

  state_t      state;
  state_t      state_next;
  logic [31:0] win [16];
  logic [5:0]  t;
  logic        accept;
  logic        last_accept;
  logic [31:0] sig0;
  logic [31:0] sig1;
  logic [31:0] w_next;

  assign accept      = (state == RUN) & w_ready;
  assign last_accept = accept & (t == LAST_T);

  // sigma0 on W[t+1], sigma1 on W[t+14]; the sum is W[t+16].
  always_comb begin
    sig0   = {win[1][6:0],   win[1][31:7]}  ^
             {win[1][17:0],  win[1][31:18]} ^
             {3'b000,        win[1][31:3]};
    sig1   = {win[14][16:0], win[14][31:17]} ^
             {win[14][18:0], win[14][31:19]} ^
             {10'd0,         win[14][31:10]};
    w_next = sig1 + win[9] + sig0 + win[0];
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state decode; abort overrides both start and accept.
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE: begin
        if (start && !abort) begin
          state_next = RUN;
        end
      end
      RUN: begin
        if (abort || last_accept) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Window, round index and done pulse.
  // The final accept does not shift or advance t, so w_out/t_out keep
  // showing W63/63 in IDLE until the next block is loaded.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 16; i++) begin
        win[i] <= '0;
      end
      t    <= '0;
      done <= 1'b0;
    end else begin
      done <= last_accept & ~abort;
      if (state == IDLE && start && !abort) begin
        for (int i = 0; i < 16; i++) begin
          win[i] <= block[511 - 32*i -: 32];
        end
        t <= '0;
      end else if (accept && !abort && !last_accept) begin
        for (int i = 0; i < 15; i++) begin
          win[i] <= win[i+1];
        end
        win[15] <= w_next;
        t       <= t + 6'd1;
      end
    end
  end

  assign w_valid = (state == RUN);
  assign busy    = (state == RUN);
  assign w_out   = win[0];
  assign t_out   = t;

endmodule
`default_nettype wire

// File: tb/tb_sha256_msg_schedule.sv
`default_nettype none
// ============================================================================
// Module   : tb_sha256_msg_schedule
// Purpose  : Self-checking bench for sha256_msg_schedule. Schedules are
//            compared against a full 64-word reference expansion, plus a
//            table of known "abc" schedule words.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sha256_msg_schedule;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic         abort;
  logic [511:0] block;
  logic         w_ready;
  logic         w_valid;
  logic [31:0]  w_out;
  logic [5:0]   t_out;
  logic         busy;
  logic         done;

  int tests = 0;
  int fails = 0;

  logic [31:0] exp_w [64];
  logic [31:0] got_w [64];

  typedef struct {
    int          t;
    logic [31:0] w;
  } vec_t;

  vec_t abc_tab [6];

  sha256_msg_schedule dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .abort   (abort),
    .block   (block),
    .w_ready (w_ready),
    .w_valid (w_valid),
    .w_out   (w_out),
    .t_out   (t_out),
    .busy    (busy),
    .done    (done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] ror(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  // Reference schedule straight from the SHA-256 recurrence.
  task automatic compute_model(input logic [511:0] b);
    logic [31:0] s0, s1;
    for (int i = 0; i < 16; i++) exp_w[i] = b[511 - 32*i -: 32];
    for (int i = 16; i < 64; i++) begin
      s0 = ror(exp_w[i-15], 7) ^ ror(exp_w[i-15], 18) ^ (exp_w[i-15] >> 3);
      s1 = ror(exp_w[i-2], 17) ^ ror(exp_w[i-2], 19) ^ (exp_w[i-2] >> 10);
      exp_w[i] = s1 + exp_w[i-7] + s0 + exp_w[i-16];
    end
  endtask

  function automatic logic [511:0] rand_block();
    logic [511:0] b;
    for (int i = 0; i < 16; i++) b[32*i +: 32] = $urandom;
    return b;
  endfunction

  // Present start with a block for one edge; returns #1 after that edge.
  task automatic launch(input logic [511:0] b);
    start = 1'b1;
    block = b;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // Consume one schedule. Entered #1 after the start edge.
  // ev_kind: 0 none, 1 start while busy, 2 abort+start, 3 async reset.
  task automatic stream(input logic [511:0] b, input bit stall,
                        input int ev_t, input int ev_kind,
                        input bit chain, input logic [511:0] nblk);
    int          acc = 0;
    int          cyc = 0;
    int          stall_left = 0;
    bit          prev_stalled = 1'b0;
    bit          ev_done = 1'b0;
    logic [31:0] prev_w = '0;
    logic [5:0]  prev_t = '0;
    compute_model(b);
    while (acc < 64 && cyc < 3000) begin
      if (!ev_done && ev_kind != 0 && acc == ev_t) begin
        ev_done = 1'b1;
        if (ev_kind == 1) begin
          start = 1'b1;
          block = ~b;
        end else if (ev_kind == 2) begin
          abort   = 1'b1;
          start   = 1'b1;
          block   = nblk;
          w_ready = 1'b1;
          @(posedge clk); #1;
          abort = 1'b0;
          start = 1'b0;
          chk("abort_valid", {31'd0, w_valid}, 32'd0);
          chk("abort_busy",  {31'd0, busy},    32'd0);
          chk("abort_done",  {31'd0, done},    32'd0);
          @(posedge clk); #1;
          chk("abort_done2", {31'd0, done},    32'd0);
          chk("abort_idle",  {31'd0, w_valid}, 32'd0);
          return;
        end else begin
          #2 rst_n = 1'b0;
          #1;
          chk("rst_valid", {31'd0, w_valid}, 32'd0);
          chk("rst_busy",  {31'd0, busy},    32'd0);
          chk("rst_done",  {31'd0, done},    32'd0);
          chk("rst_w_out", w_out,            32'd0);
          chk("rst_t_out", {26'd0, t_out},   32'd0);
          #1 rst_n = 1'b1;
          return;
        end
      end
      if (stall) begin
        if (stall_left == 0 && $urandom_range(0, 2) == 0)
          stall_left = $urandom_range(1, 10);
        w_ready = (stall_left == 0);
        if (stall_left > 0) stall_left--;
      end else begin
        w_ready = 1'b1;
      end
      if (prev_stalled) begin
        chk("stall_w", w_out, prev_w);
        chk("stall_t", {26'd0, t_out}, {26'd0, prev_t});
      end
      chk("valid", {31'd0, w_valid}, 32'd1);
      if (w_ready) begin
        got_w[acc] = w_out;
        chk("word", w_out, exp_w[acc]);
        chk("t_out", {26'd0, t_out}, acc);
        acc++;
      end
      prev_w       = w_out;
      prev_t       = t_out;
      prev_stalled = !w_ready;
      @(posedge clk); #1;
      start = 1'b0;
      cyc++;
    end
    if (acc < 64) chk("timeout_accepts", acc, 64);
    if (!stall) chk("latency", cyc, 64);
    chk("done_pulse", {31'd0, done},    32'd1);
    chk("done_valid", {31'd0, w_valid}, 32'd0);
    chk("done_busy",  {31'd0, busy},    32'd0);
    w_ready = 1'b1;
    if (chain) begin
      start = 1'b1;
      block = nblk;
    end
    @(posedge clk); #1;
    start = 1'b0;
    chk("done_once", {31'd0, done}, 32'd0);
    if (!chain) chk("idle_valid", {31'd0, w_valid}, 32'd0);
  endtask

  initial begin
    logic [511:0] abc;
    logic [511:0] b2;
    logic [511:0] b3;
    abc = {32'h61626380, {14{32'h00000000}}, 32'h00000018};
    abc_tab[0] = '{0,  32'h61626380};
    abc_tab[1] = '{15, 32'h00000018};
    abc_tab[2] = '{16, 32'h61626380};
    abc_tab[3] = '{17, 32'h000F0000};
    abc_tab[4] = '{63, 32'h12B1EDEB};
    abc_tab[5] = '{1,  32'h00000000};

    rst_n = 1'b1; start = 1'b0; abort = 1'b0; w_ready = 1'b0; block = '0;
    #1 rst_n = 1'b0;
    #1;
    chk("reset_valid", {31'd0, w_valid}, 32'd0);
    chk("reset_busy",  {31'd0, busy},    32'd0);
    chk("reset_done",  {31'd0, done},    32'd0);
    chk("reset_w_out", w_out,            32'd0);
    chk("reset_t_out", {26'd0, t_out},   32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // "abc" with no backpressure, then table of known words
    launch(abc);
    stream(abc, 1'b0, 0, 0, 1'b0, '0);
    for (int i = 0; i < 6; i++)
      chk($sformatf("abc_W%0d", abc_tab[i].t), got_w[abc_tab[i].t], abc_tab[i].w);
    chk("idle_hold_t", {26'd0, t_out}, 32'd63);

    // "abc" with random stalls
    launch(abc);
    stream(abc, 1'b1, 0, 0, 1'b0, '0);

    // Back-to-back blocks
    b2 = rand_block();
    launch(abc);
    stream(abc, 1'b0, 0, 0, 1'b1, b2);
    stream(b2, 1'b1, 0, 0, 1'b0, '0);

    // start while busy at t = 20
    launch(b2);
    stream(b2, 1'b0, 20, 1, 1'b0, '0);

    // abort together with start at t = 30, then a clean run
    b3 = rand_block();
    launch(abc);
    stream(abc, 1'b0, 30, 2, 1'b0, b3);
    launch(b3);
    stream(b3, 1'b0, 0, 0, 1'b0, '0);

    // async reset at t = 40, then a clean run
    launch(b3);
    stream(b3, 1'b1, 40, 3, 1'b0, '0);
    launch(b2);
    stream(b2, 1'b0, 0, 0, 1'b0, '0);

    // Random blocks with random backpressure
    for (int n = 0; n < 4; n++) begin
      b3 = rand_block();
      launch(b3);
      stream(b3, 1'b1, 0, 0, 1'b0, '0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
